// File: rtl/Subsystem_pkg.sv
// -----------------------------------------------------------------------------
// Subsystem_pkg
// Shared types and default timing constants for the DAC bank sequencer.
//   dac_seq_state_t            : sequencer FSM states
//   vector_of_signed_logic_12  : signed 12-bit DAC channel word
//   DEF_*                      : default parameter values
//   clog2_min1 / max3          : width helpers for counters
// -----------------------------------------------------------------------------
package Subsystem_pkg;

    localparam int DEF_NUM_CH     = 8;
    localparam int DEF_SLOTS      = 4;
    localparam int DEF_DATA_W     = 12;
    localparam int DEF_WR_W       = 8;
    localparam int DEF_SETUP_CYC  = 8;
    localparam int DEF_STROBE_CYC = 1;
    localparam int DEF_HOLD_CYC   = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } dac_seq_state_t;

    typedef logic signed [11:0] vector_of_signed_logic_12;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dac_seq_timer.sv
// -----------------------------------------------------------------------------
// dac_seq_timer
// Loadable down-counter used to time each sequencer phase. Loading N makes
// the terminal count appear N cycles later, so a phase of D cycles loads D-1.
//   clk_in, reset_n : clock, asynchronous active-low reset
//   load_i          : load load_val_i on the next edge
//   load_val_i      : value to load
//   tc_o            : counter is at zero (last cycle of the phase)
// -----------------------------------------------------------------------------
module dac_seq_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: cnt_d gets its default before any branch so no path leaves it
    // unassigned; otherwise a latch would be inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/dac_bank_sequencer.sv
// -----------------------------------------------------------------------------
// dac_bank_sequencer
// On a rising edge of trig, snapshots all channel words and drives them bank
// by bank (highest bank first) onto a shared SLOTS-wide DAC bus, with a
// setup / strobe / hold cycle for each bank's write strobe. One trigger may be
// queued while busy; a further one is dropped and flagged.
//   clk_in, reset_n : clock, asynchronous active-low reset
//   enable          : strobe gate, latched at sequence start
//   trig            : level request, rising edge starts a sequence
//   ch_data         : NUM_CH signed channel words
//   slot_out        : shared DAC data bus (SLOTS words)
//   wr_out          : per-bank write strobes, WR_W replicated bits each
//   busy            : sequence in progress
//   done            : one-cycle completion pulse
//   overrun         : one-cycle pulse when a trigger is dropped
// -----------------------------------------------------------------------------
module dac_bank_sequencer
    import Subsystem_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int SLOTS      = DEF_SLOTS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int WR_W       = DEF_WR_W,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic                                 clk_in,
    input  logic                                 reset_n,
    input  logic                                 enable,
    input  logic                                 trig,
    input  logic signed [DATA_W-1:0]             ch_data  [NUM_CH],
    output logic signed [DATA_W-1:0]             slot_out [SLOTS],
    output logic [NUM_CH/SLOTS-1:0][WR_W-1:0]    wr_out,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overrun
);

    localparam int NUM_BANKS = NUM_CH / SLOTS;
    localparam int CNT_W     = clog2_min1(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC));
    localparam int BANK_W    = clog2_min1(NUM_BANKS);

    if (SLOTS < 1 || NUM_CH % SLOTS != 0) begin : g_bad_num_ch
        $error("dac_bank_sequencer: NUM_CH must be a non-zero multiple of SLOTS");
    end
    if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_timing
        $error("dac_bank_sequencer: SETUP_CYC, STROBE_CYC and HOLD_CYC must be >= 1");
    end

    dac_seq_state_t          state_q, state_d;
    logic [BANK_W-1:0]       bank_q, bank_d;
    logic [BANK_W-1:0]       next_bank;
    logic                    en_q, en_d;
    logic                    pend_q, pend_d;
    logic                    trig_q;
    logic                    trig_edge;
    logic signed [DATA_W-1:0] snap_q [NUM_CH];
    logic signed [DATA_W-1:0] snap_d [NUM_CH];
    logic signed [DATA_W-1:0] slot_q [SLOTS];
    logic signed [DATA_W-1:0] slot_d [SLOTS];

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_tc;

    dac_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    assign trig_edge = trig & ~trig_q;
    assign next_bank = bank_q - BANK_W'(1);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign slot_out  = slot_q;

    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        en_d     = en_q;
        pend_d   = pend_q;
        snap_d   = snap_q;
        slot_d   = slot_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        wr_out   = '0;
        overrun  = 1'b0;

        // While a sequence runs, one trigger can wait; any further one is lost.
        if (state_q != IDLE && trig_edge) begin
            if (pend_q) begin
                overrun = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (trig_edge || pend_q) begin
                    snap_d   = ch_data;
                    en_d     = enable;
                    pend_d   = 1'b0;
                    bank_d   = BANK_W'(NUM_BANKS - 1);
                    // First bank goes straight from the live inputs so the bus
                    // updates on the cycle after detection.
                    for (int s = 0; s < SLOTS; s++) begin
                        slot_d[s] = ch_data[s*NUM_BANKS + NUM_BANKS - 1];
                    end
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(SETUP_CYC - 1);
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(STROBE_CYC - 1);
                    state_d  = STROBE;
                end
            end
            STROBE: begin
                if (en_q) begin
                    wr_out[bank_q] = '1;
                end
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(HOLD_CYC - 1);
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (tmr_tc) begin
                    if (bank_q == '0) begin
                        state_d = DONE;
                    end else begin
                        bank_d = next_bank;
                        // Banks are interleaved: slot s of bank b is channel s*NUM_BANKS+b.
                        for (int b = 0; b < NUM_BANKS; b++) begin
                            if (BANK_W'(b) == next_bank) begin
                                for (int s = 0; s < SLOTS; s++) begin
                                    slot_d[s] = snap_q[s*NUM_BANKS + b];
                                end
                            end
                        end
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(SETUP_CYC - 1);
                        state_d  = SETUP;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the snapshot and slot arrays are cleared by reset because their
    // zero state is visible on slot_out; plain storage arrays would not be.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            bank_q  <= '0;
            en_q    <= 1'b0;
            pend_q  <= 1'b0;
            trig_q  <= 1'b0;
            snap_q  <= '{default: '0};
            slot_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
            trig_q  <= trig;
            snap_q  <= snap_d;
            slot_q  <= slot_d;
        end
    end

endmodule

// File: doc/dac_bank_sequencer.md
DAC_BANK_SEQUENCER -- requirements
Module: dac_bank_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, meaning total DAC channels; must be a multiple of SLOTS.
REQ-002 SHALL have parameter SLOTS, default 4, meaning shared DAC data slots per bank; NUM_BANKS = NUM_CH/SLOTS.
REQ-003 SHALL have parameter DATA_W, default 12, meaning signed channel word width.
REQ-004 SHALL have parameter WR_W, default 8, meaning strobe bits per bank (replicated strobe).
REQ-005 SHALL have parameter SETUP_CYC, default 8, meaning cycles from slot update to strobe; >=1.
REQ-006 SHALL have parameter STROBE_CYC, default 1, meaning strobe width in cycles; >=1.
REQ-007 SHALL have parameter HOLD_CYC, default 4, meaning slot hold cycles after strobe; >=1.
REQ-008 SHALL have port clk_in, input, 1, meaning the single clock; all logic on its rising edge.
REQ-009 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-010 SHALL have port enable, input, 1, meaning strobe enable (manual write gate).
REQ-011 SHALL have port trig, input, 1, meaning level request; its rising edge starts a sequence.
REQ-012 SHALL have port ch_data, input, NUM_CH x DATA_W signed, meaning channel words.
REQ-013 SHALL have port slot_out, output, SLOTS x DATA_W signed, meaning shared DAC data bus.
REQ-014 SHALL have port wr_out, output, NUM_BANKS x WR_W, meaning per-bank write strobes.
REQ-015 SHALL have outputs busy (1), done (1) and overrun (1): sequence active, completion pulse, dropped-trigger pulse.

Function
REQ-016 SHALL detect a trigger edge as trig=1 with the registered previous trig=0; the detection edge is cycle 0.
REQ-017 On a trigger edge in IDLE, SHALL snapshot all ch_data and latch enable; later ch_data/enable changes SHALL not affect that sequence.
REQ-018 SHALL map bank b, slot s to channel s*NUM_BANKS+b (interleaved).
REQ-019 SHALL service banks in descending order, NUM_BANKS-1 down to 0.
REQ-020 With P = SETUP_CYC+STROBE_CYC+HOLD_CYC and k the service index (0 first), slot_out SHALL take bank words at cycle 1+k*P.
REQ-021 SHALL drive the bank's wr_out to all-ones for cycles 1+k*P+SETUP_CYC through 1+k*P+SETUP_CYC+STROBE_CYC-1 if latched enable=1, and keep it zero otherwise.
REQ-022 SHALL hold slot_out constant from its update through the bank's final HOLD cycle; at most one bank strobe is active at any time.
REQ-023 SHALL pulse done for one cycle at cycle 1+NUM_BANKS*P and return to IDLE on the next cycle.
REQ-024 busy SHALL be 1 for cycles 1 through 1+NUM_BANKS*P inclusive and 0 in IDLE.
REQ-025 SHALL use states IDLE -> SETUP -> STROBE -> HOLD -> (SETUP of next bank | DONE) -> IDLE.
REQ-026 A trigger edge while busy SHALL set a one-deep pending flag; the pending sequence SHALL start with snapshot on the first IDLE cycle after DONE, and that cycle counts as cycle 0.
REQ-027 A trigger edge while busy with pending already set SHALL be dropped and SHALL pulse overrun for one cycle.
REQ-028 slot_out SHALL retain its last value in IDLE.

Reset
REQ-029 reset_n=0 SHALL immediately force: state IDLE, slot_out all zero, wr_out zero, busy/done/overrun 0, pending 0, previous-trig register 0, snapshot zero.
REQ-030 Reset mid-sequence SHALL abort with no further strobes; after reset_n rises, a trig already high SHALL count as an edge.

Structure
REQ-031 The state enum dac_seq_state_t and the signed word type vector_of_signed_logic_12 SHALL reside in Subsystem_pkg; the default timing constants SHALL also reside there.
REQ-032 Counter widths SHALL be $clog2-derived from parameters; an elaboration check SHALL reject NUM_CH not divisible by SLOTS.
REQ-033 One sub-module, dac_seq_timer (load/terminal-count down-counter), SHALL be used; no other hierarchy.

Verification (defaults; P=13)
REQ-034 Channel c data=c+1, enable=1, trig rises: slot_out={2,4,6,8} at cycle 1; wr_out[1]=8'hFF at cycle 9 only; slot_out={1,3,5,7} at cycle 14; wr_out[0]=8'hFF at cycle 22; done at cycle 27.
REQ-035 Same with enable=0 at trigger then 1 at cycle 5: slot_out sequences identically, wr_out stays zero throughout.
REQ-036 ch_data changed to all 100 at cycle 3: slot_out still shows the snapshot values at cycle 14.
REQ-037 Second trig edge at cycle 10, third at cycle 15: overrun pulses at the third edge's detection cycle; the second sequence starts at cycle 28, with slot_out updated at cycle 29 and done at cycle 55.
REQ-038 reset_n low at cycle 9 during the strobe: wr_out=0, busy=0 and slot_out=0 at once; no done pulse.
REQ-039 Parameters NUM_CH=12, SLOTS=4, STROBE_CYC=3: three banks serviced in order 2,1,0, each strobe 3 cycles wide, done at cycle 1+3*15=46.
